regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the NPC core. It generalises the fixed 2-read/1-write, 32x32 register file.
- Configurable width, depth (RV32I/RV32E), read-port count and write-port count.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: the IDU reserves a destination, the EXU/WBU releases it, and the IDU uses the busy status to stall on RAW/WAW hazards.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (16 for RV32E); must be a power of 2 and at least 2
NRD, 2, number of read ports (1..4)
NWR, 1, number of write ports (1..2)
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored contents only
AW, $clog2(NREG), localparam, register address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
raddr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW]
rdata  out  NRD*XLEN  read data; port i is bits [i*XLEN +: XLEN]
rbusy  out  NRD  read port i targets a register with a pending write
waddr  in  NWR*AW  write addresses, packed in the same way as raddr
wdata  in  NWR*XLEN  write data
wen  in  NWR  write enable per write port
wclr  in  NWR  write port also releases the busy bit of waddr
alloc_en  in  1  reserve destination alloc_addr (set its busy bit)
alloc_addr  in  AW  destination register to reserve
alloc_conflict  out  1  alloc_addr is currently busy (WAW); combinational
flush  in  1  clear all busy bits; register contents are unaffected
busy_vec  out  NREG  current busy bits, for debug/difftest

Behaviour:
- Storage: NREG x XLEN flops.
- On rst, every register is cleared to 0 and every busy bit is cleared to 0 at the clock edge. rst overrides wen, alloc_en and flush.
- After reset, all outputs read 0: rdata=0, rbusy=0, alloc_conflict=0, busy_vec=0.
- Register 0:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0.
  - busy[0] is constantly 0; alloc_en with address 0 is a no-op and alloc_conflict=0.
- Write ports:
  - On the clock edge, regs[waddr[j]] <= wdata[j] when wen[j]=1 and waddr[j]!=0.
  - If two ports write the same address in one cycle, the higher port index wins.
- Read ports are combinational, with zero-cycle latency.
  - BYPASS=1: if any wen[j]=1 and waddr[j]==raddr[i]!=0, rdata[i] = wdata of the highest such j. Otherwise rdata[i] = regs[raddr[i]].
  - BYPASS=0: rdata[i] = regs[raddr[i]]. New data is visible one cycle after the write.
- Scoreboard next-state, per register r!=0, evaluated in priority order:
  1. flush=1 -> busy[r] <= 0. flush overrides alloc_en and wclr in the same cycle.
  2. alloc_en=1 and alloc_addr==r -> busy[r] <= 1. Set wins over a same-cycle clear, because the newer instruction owns the register.
  3. Any j with wen[j]=1, wclr[j]=1 and waddr[j]==r -> busy[r] <= 0.
  4. Otherwise busy[r] holds.
- wclr is qualified by wen: wclr=1 with wen=0 has no effect.
- rbusy[i] = busy[raddr[i]], except:
  - it is 0 when raddr[i]==0;
  - BYPASS=1: it is 0 when a same-cycle wen&wclr write to raddr[i] is present, since the data is being forwarded.
- alloc_conflict = busy[alloc_addr] & (alloc_addr!=0). It is informational only: allocation still sets the bit, and the IDU must stall on it.
- Address range: when NREG is smaller than 2^AW no out-of-range addresses exist, because NREG is a power of 2.
- Reset mid-operation: all pending busy bits are lost. Writes arriving in the same cycle as rst are discarded.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with wen=1, waddr=5, wdata=0xDEADBEEF. Then read all 32 addresses -> every rdata=0, busy_vec=0.
- x0 protection: write 0x12345678 to address 0, then read raddr=0 on both ports -> rdata=0 and rbusy=0. Assert alloc_en with alloc_addr=0 -> busy_vec stays 0.
- Bypass: BYPASS=1, write wen=1, waddr=7, wdata=0xA5A5A5A5 with raddr0=7 in the same cycle -> rdata0=0xA5A5A5A5 in that cycle. Repeat with BYPASS=0 -> old value in that cycle, then 0xA5A5A5A5 in the next cycle.
- Dual-write collision: NWR=2, both ports write address 3 with 0x11 on port 0 and 0x22 on port 1 -> the next read of 3 returns 0x22.
- Scoreboard lifecycle:
  - alloc_en with address 9 -> busy_vec[9]=1 next cycle, and rbusy=1 when raddr=9.
  - alloc_en 9 again -> alloc_conflict=1.
  - wen&wclr to 9 together with alloc_en 9 in the same cycle -> busy[9] stays 1.
  - wen&wclr to 9 alone -> busy[9]=0.
- Flush priority: set busy on 4, 5 and 6, then flush=1 together with alloc_en to 8 -> busy_vec=0 next cycle, and register contents are unchanged on readback.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port integer register file with a per-register busy
// scoreboard. The decode stage reserves a destination with alloc_en, and a
// write port releases it with wclr. The read ports report the busy status so
// that decode can stall on RAW and WAW hazards. Register 0 is hardwired to
// zero and is never busy.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR-1:0]      wclr,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                alloc_conflict,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW-1:0]   ra;

    // Register storage: write ports are applied in ascending order, so the
    // highest-indexed port wins when two ports hit the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the architecture needs all registers to read zero after
            // reset, so this array is built from flops that have a reset.
            // It is not a RAM macro.
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
                    regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard next state. Each later assignment overrides the earlier
    // ones, so the order gives the priority: clear, then alloc set, then flush.
    always_comb begin
        // NOTE: blocking assignments here build the value step by step.
        // Each later statement overrides the earlier ones.
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j] && wclr[j]) begin
                busy_nxt[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register. Reset drops every pending reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Combinational read ports. Same-cycle writes are forwarded when BYPASS
    // is set. A forwarded write that also clears the busy bit hides that bit.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra                      = raddr[i*AW +: AW];
            rdata[i*XLEN +: XLEN]   = regs[ra];
            rbusy[i]                = busy[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
                        rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
                        if (wclr[j]) begin
                            rbusy[i] = 1'b0;
                        end
                    end
                end
            end
            if (ra == '0) begin
                rdata[i*XLEN +: XLEN] = '0;
                rbusy[i]              = 1'b0;
            end
        end
    end

    // WAW hint for decode. Register 0 is never busy, so it never conflicts.
    always_comb begin
        alloc_conflict = busy[alloc_addr] && (alloc_addr != '0);
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Testbench for regfile_mp_sb. It drives two instances with the same
// stimulus: one with bypass enabled and one without. Both have two write
// ports. Outputs are compared against a register/scoreboard model built from
// the architectural rules.
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NWR-1:0]      wen;
    logic [NWR-1:0]      wclr;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                flush;

    logic [NRD*XLEN-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic                conf_b, conf_n;
    logic [NREG-1:0]     bvec_b, bvec_n;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .waddr(waddr), .wdata(wdata), .wen(wen), .wclr(wclr),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_conflict(conf_b),
        .flush(flush), .busy_vec(bvec_b)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .waddr(waddr), .wdata(wdata), .wen(wen), .wclr(wclr),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_conflict(conf_n),
        .flush(flush), .busy_vec(bvec_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [AW-1:0] rd_a(input int i);
        return raddr[i*AW +: AW];
    endfunction

    // Read result: the newest same-cycle write if forwarding, else stored value.
    function automatic logic [XLEN-1:0] exp_rdata(input int i, input bit byp);
        logic [AW-1:0] a = rd_a(i);
        if (a == 0) return '0;
        if (byp) begin
            for (int j = NWR - 1; j >= 0; j--) begin
                if (wen[j] && waddr[j*AW +: AW] == a) return wdata[j*XLEN +: XLEN];
            end
        end
        return m_regs[a];
    endfunction

    function automatic bit exp_rbusy(input int i, input bit byp);
        logic [AW-1:0] a = rd_a(i);
        if (a == 0) return 1'b0;
        if (byp) begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && wclr[j] && waddr[j*AW +: AW] == a) return 1'b0;
            end
        end
        return m_busy[a];
    endfunction

    function automatic logic [NREG-1:0] exp_bvec();
        logic [NREG-1:0] v = '0;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // Apply one rising edge to the model, using the inputs present at the edge.
    task automatic model_update();
        bit nb [NREG];
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                bit cleared = 1'b0;
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && wclr[j] && waddr[j*AW +: AW] == r) cleared = 1'b1;
                end
                if (flush) nb[r] = 1'b0;
                else if (alloc_en && alloc_addr == r) nb[r] = 1'b1;
                else if (cleared) nb[r] = 1'b0;
                else nb[r] = m_busy[r];
            end
            nb[0] = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && waddr[j*AW +: AW] != 0) m_regs[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
            end
            for (int r = 0; r < NREG; r++) m_busy[r] = nb[r];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; raddr = '0; waddr = '0; wdata = '0; wen = '0; wclr = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        #1;
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("%s rdata_b[%0d]", tag, i), rdata_b[i*XLEN +: XLEN], exp_rdata(i, 1'b1));
            check($sformatf("%s rdata_n[%0d]", tag, i), rdata_n[i*XLEN +: XLEN], exp_rdata(i, 1'b0));
            check($sformatf("%s rbusy_b[%0d]", tag, i), rbusy_b[i], exp_rbusy(i, 1'b1));
            check($sformatf("%s rbusy_n[%0d]", tag, i), rbusy_n[i], exp_rbusy(i, 1'b0));
        end
        check({tag, " conf_b"}, conf_b, m_busy[alloc_addr] && alloc_addr != 0);
        check({tag, " conf_n"}, conf_n, m_busy[alloc_addr] && alloc_addr != 0);
        check({tag, " bvec_b"}, bvec_b, exp_bvec());
        check({tag, " bvec_n"}, bvec_n, exp_bvec());
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = 'x;
            m_busy[r] = 1'b0;
        end
        idle();

        // Reset for two cycles while a write is attempted.
        rst = 1'b1; wen = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
        #1;
        step();
        step();
        idle();
        for (int a = 0; a < NREG; a++) begin
            raddr = {a[4:0], a[4:0]};
            #1;
            check($sformatf("reset rd0 a=%0d", a), rdata_b[31:0], 32'h0);
            check($sformatf("reset rd1n a=%0d", a), rdata_n[63:32], 32'h0);
        end
        check("reset busy_vec", bvec_b, 32'h0);
        check_outputs("reset");

        // Register 0 ignores writes and allocations.
        wen = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'h12345678;
        step();
        idle();
        check_outputs("x0 read");
        check("x0 rdata", rdata_b, 64'h0);
        alloc_en = 1'b1; alloc_addr = 5'd0;
        check_outputs("x0 alloc");
        step();
        idle();
        check("x0 busy_vec", bvec_b, 32'h0);

        // Same-cycle forwarding versus a one-cycle-late update.
        wen = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'hA5A5A5A5; raddr[4:0] = 5'd7;
        check_outputs("bypass same");
        check("bypass fwd", rdata_b[31:0], 32'hA5A5A5A5);
        check("nobypass old", rdata_n[31:0], 32'h0);
        step();
        idle(); raddr[4:0] = 5'd7;
        check_outputs("bypass next");
        check("nobypass new", rdata_n[31:0], 32'hA5A5A5A5);

        // Both write ports target the same address. Port 1 must win.
        wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11}; raddr = {5'd3, 5'd3};
        check_outputs("dual same");
        step();
        idle(); raddr = {5'd3, 5'd3};
        check_outputs("dual next");
        check("dual winner", rdata_n[31:0], 32'h22);

        // Scoreboard lifecycle on register 9.
        alloc_en = 1'b1; alloc_addr = 5'd9;
        check("alloc9 no conflict", conf_b, 1'b0);
        step();
        idle(); raddr[4:0] = 5'd9;
        check_outputs("alloc9");
        check("busy9 set", bvec_b[9], 1'b1);
        check("rbusy9", rbusy_b[0], 1'b1);
        alloc_en = 1'b1; alloc_addr = 5'd9;
        #1;
        check("alloc9 conflict", conf_b, 1'b1);
        step();
        wen = 2'b01; wclr = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h99;
        alloc_en = 1'b1; alloc_addr = 5'd9; raddr[4:0] = 5'd9;
        check_outputs("clr+alloc9");
        step();
        idle();
        check("busy9 kept", bvec_b[9], 1'b1);
        wen = 2'b01; wclr = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h9A;
        step();
        idle();
        check("busy9 released", bvec_b[9], 1'b0);

        // A flush beats a same-cycle allocation and leaves data intact.
        wen = 2'b11; waddr = {5'd5, 5'd4}; wdata = {32'h55, 32'h44};
        step();
        idle(); wen = 2'b01; waddr[4:0] = 5'd6; wdata[31:0] = 32'h66;
        step();
        for (int r = 4; r <= 6; r++) begin
            idle(); alloc_en = 1'b1; alloc_addr = r[4:0];
            step();
        end
        idle();
        check("busy 4-6", bvec_b[6:4], 3'b111);
        flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd8;
        step();
        idle();
        check("flush busy_vec", bvec_b, 32'h0);
        raddr = {5'd5, 5'd4};
        check_outputs("flush read45");
        check("flush keep4", rdata_n[31:0], 32'h44);
        check("flush keep5", rdata_n[63:32], 32'h55);
        raddr[4:0] = 5'd6;
        #1;
        check("flush keep6", rdata_b[31:0], 32'h66);

        // Random traffic. Addresses are biased to a small range so that
        // collisions are frequent.
        for (int k = 0; k < 400; k++) begin
            rst        = ($urandom_range(0, 99) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            alloc_en   = $urandom_range(0, 1);
            alloc_addr = 5'($urandom_range(0, 7));
            wen        = 2'($urandom);
            wclr       = 2'($urandom);
            for (int j = 0; j < NWR; j++) begin
                waddr[j*AW +: AW]   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                wdata[j*XLEN +: XLEN] = $urandom;
            end
            for (int i = 0; i < NRD; i++) begin
                raddr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            end
            check_outputs($sformatf("rand%0d", k));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
